mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset; one clock, synchronous active-high reset.
REQ-002 SHALL have execute-side inputs: pcM 64, instM 32, memFuncM 11, RamReadAddrM 64, RamWriteAddrM 64, RamWriteDataM 64, RamReadEnableM 1, RamWriteEnableM 1, rdWriteEnableM 1, rdWriteAddrM 5, rdWriteDataM 64.
REQ-003 SHALL use one-hot memFuncM: bit0 lb, bit1 lh, bit2 lw, bit3 ld, bit4 lbu, bit5 lhu, bit6 lwu, bit7 sb, bit8 sh, bit9 sw, bit10 sd.
REQ-004 SHALL have RAM port: ram_req out 1; ram_we out 1; ram_addr out 64, always 8-byte aligned; ram_wdata out 64; ram_wmask out 8, byte enables; ram_ready in 1; ram_rdata in 64, valid when ram_ready=1.
REQ-005 SHALL have outputs: stallReqM out 1, to ctrl; rdWriteEnableW out 1; rdWriteAddrW out 5; rdWriteDataW out 64; pcW out 64; instW out 32; commitW out 1, valid retire; misalignW out 1.

Function
REQ-006 SHALL define access = RamReadEnableM | RamWriteEnableM, and addr = RamReadAddrM for loads, RamWriteAddrM for stores.
REQ-007 SHALL flag misaligned when: lh/lhu/sh with addr[0]!=0; lw/lwu/sw with addr[1:0]!=0; ld/sd with addr[2:0]!=0.
REQ-008 SHALL implement a 2-state FSM.
- IDLE: if access & !misaligned & !ram_ready, go to WAIT; otherwise stay in IDLE.
- WAIT: on ram_ready, go to IDLE.
REQ-009 SHALL drive ram_req=1 combinationally in IDLE when access & !misaligned, and hold it at 1 throughout WAIT.
- ram_req SHALL be 0 while rst=1.
REQ-010 SHALL hold ram_addr = {addr[63:3],3'b000}, ram_we = RamWriteEnableM, and ram_wdata/ram_wmask stable while ram_req=1.
REQ-011 SHALL form store data for offset o=addr[2:0]:
- sb: ram_wdata = data[7:0] << 8o, ram_wmask = 8'h01<<o.
- sh: ram_wdata = data[15:0] << 8o, ram_wmask = 8'h03<<o.
- sw: ram_wdata = data[31:0] << 8o, ram_wmask = 8'h0F<<o.
- sd: ram_wmask = 8'hFF.
- Loads: ram_wmask = 0.
REQ-012 SHALL extract load data as ram_rdata >> 8o, truncated to 8/16/32/64 bits.
- lb/lh/lw: sign-extended to 64.
- lbu/lhu/lwu: zero-extended to 64.
REQ-013 SHALL assert stallReqM combinationally = (IDLE & access & !misaligned & !ram_ready) | (WAIT & !ram_ready).
- Upstream holds all M-inputs stable while stallReqM=1.
REQ-014 SHALL register W outputs on every clock edge with stallReqM=0.
- Non-memory instruction: 1-cycle latency; rdWriteDataW = rdWriteDataM.
- Load: rdWriteDataW = extracted data.
- Store: rdWriteEnableW = 0.
- Otherwise rdWriteEnableW = rdWriteEnableM.
REQ-015 SHALL register a bubble on every edge with stallReqM=1: commitW=0, rdWriteEnableW=0, other W outputs unchanged.
REQ-016 SHALL, when ram_ready=1 in the same IDLE cycle as the request, complete zero-wait with no stall.
REQ-017 SHALL handle a misaligned access in one cycle:
- no ram_req;
- W edge with misalignW=1, commitW=1, rdWriteEnableW=0.
REQ-018 SHALL ignore ram_ready when ram_req=0.
REQ-019 SHALL have no flush input; every instruction entering M retires exactly once.
REQ-020 SHALL treat instM=0 with no enables as a bubble and register commitW=0.

Reset
REQ-021 SHALL, on a rising edge with rst=1, set: state IDLE; commitW, misalignW, rdWriteEnableW = 0; rdWriteAddrW=0, rdWriteDataW=0, pcW=0, instW=0.
REQ-022 SHALL, on rst asserted during WAIT, abandon the access: ram_req=0 from the reset cycle on, no W write, and ignore any later ram_ready for that access.
REQ-023 SHALL produce stallReqM=0 while rst=1.

Verification
REQ-024 SHALL pass: add x5, rdWriteDataM=64'h1234 -> next edge rdWriteEnableW=1, rdWriteAddrW=5, rdWriteDataW=64'h1234, commitW=1, stallReqM=0 throughout.
REQ-025 SHALL pass: lb addr=0x8000_0003, ram_rdata=64'h0000_0000_80FF_0000, ram_ready after 2 WAIT cycles.
- ram_addr = 0x8000_0000; stallReqM=1 for 3 cycles; commitW=0 during them.
- Then rdWriteDataW = 64'hFFFF_FFFF_FFFF_FF80.
REQ-026 SHALL pass: sh addr=0x8000_0006, data=64'hABCD, ram_ready same cycle.
- ram_wmask=8'hC0, ram_wdata=64'hABCD_0000_0000_0000, ram_we=1, no stall.
- Next edge: commitW=1, rdWriteEnableW=0.
REQ-027 SHALL pass: lw addr=0x8000_0002 -> ram_req=0, stallReqM=0; next edge misalignW=1, rdWriteEnableW=0.
REQ-028 SHALL pass: lwu addr=0x8000_0004, ram_rdata=64'h8765_4321_0000_0000, zero-wait -> rdWriteDataW = 64'h0000_0000_8765_4321.
REQ-029 SHALL pass: ld enters WAIT, rst=1 one cycle, then ram_ready=1 -> state IDLE, ram_req=0, all W outputs zero, commitW stays 0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: aligned 64-bit RAM access with byte-lane steering, load extension,
// a request/wait FSM that stalls upstream, and registered W-stage outputs.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pcM,
  input  logic [31:0] instM,
  input  logic [10:0] memFuncM,
  input  logic [63:0] RamReadAddrM,
  input  logic [63:0] RamWriteAddrM,
  input  logic [63:0] RamWriteDataM,
  input  logic        RamReadEnableM,
  input  logic        RamWriteEnableM,
  input  logic        rdWriteEnableM,
  input  logic [4:0]  rdWriteAddrM,
  input  logic [63:0] rdWriteDataM,
  output logic        ram_req,
  output logic        ram_we,
  output logic [63:0] ram_addr,
  output logic [63:0] ram_wdata,
  output logic [7:0]  ram_wmask,
  input  logic        ram_ready,
  input  logic [63:0] ram_rdata,
  output logic        stallReqM,
  output logic        rdWriteEnableW,
  output logic [4:0]  rdWriteAddrW,
  output logic [63:0] rdWriteDataW,
  output logic [63:0] pcW,
  output logic [31:0] instW,
  output logic        commitW,
  output logic        misalignW
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_q, state_d;
  logic        rd_we_q, rd_we_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [63:0] rd_data_q, rd_data_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        commit_q, commit_d;
  logic        misalign_q, misalign_d;

  logic        access, misaligned, go, is_load;
  logic [63:0] addr, shifted, load_data;
  logic [2:0]  off;
  logic [5:0]  sh_amt;

  always_comb begin
    access  = RamReadEnableM | RamWriteEnableM;
    addr    = RamWriteEnableM ? RamWriteAddrM : RamReadAddrM;
    off     = addr[2:0];
    sh_amt  = {off, 3'b000};
    misaligned = access & (
        ((memFuncM[1] | memFuncM[5] | memFuncM[8]) & addr[0]) |
        ((memFuncM[2] | memFuncM[6] | memFuncM[9]) & (|addr[1:0])) |
        ((memFuncM[3] | memFuncM[10]) & (|addr[2:0])));
    go      = access & ~misaligned;
    is_load = RamReadEnableM & ~RamWriteEnableM;

    ram_req   = ~rst & ((state_q == IDLE & go) | (state_q == WAIT));
    stallReqM = ~rst & ((state_q == IDLE & go & ~ram_ready) | (state_q == WAIT & ~ram_ready));
    ram_addr  = {addr[63:3], 3'b000};
    ram_we    = RamWriteEnableM;

    ram_wdata = 64'd0;
    ram_wmask = 8'h00;
    if (memFuncM[7]) begin
      ram_wdata = {56'd0, RamWriteDataM[7:0]} << sh_amt;
      ram_wmask = 8'h01 << off;
    end else if (memFuncM[8]) begin
      ram_wdata = {48'd0, RamWriteDataM[15:0]} << sh_amt;
      ram_wmask = 8'h03 << off;
    end else if (memFuncM[9]) begin
      ram_wdata = {32'd0, RamWriteDataM[31:0]} << sh_amt;
      ram_wmask = 8'h0F << off;
    end else if (memFuncM[10]) begin
      ram_wdata = RamWriteDataM;
      ram_wmask = 8'hFF;
    end

    shifted = ram_rdata >> sh_amt;
    if (memFuncM[0])      load_data = {{56{shifted[7]}},  shifted[7:0]};
    else if (memFuncM[1]) load_data = {{48{shifted[15]}}, shifted[15:0]};
    else if (memFuncM[2]) load_data = {{32{shifted[31]}}, shifted[31:0]};
    else if (memFuncM[4]) load_data = {56'd0, shifted[7:0]};
    else if (memFuncM[5]) load_data = {48'd0, shifted[15:0]};
    else if (memFuncM[6]) load_data = {32'd0, shifted[31:0]};
    else                  load_data = shifted;

    state_d = state_q;
    case (state_q)
      IDLE: if (go & ~ram_ready) state_d = WAIT;
      WAIT: if (ram_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A stalled edge registers a bubble; the rest of the W bundle holds.
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    misalign_d = misalign_q;
    commit_d   = 1'b0;
    rd_we_d    = 1'b0;
    if (!stallReqM) begin
      rd_addr_d  = rdWriteAddrM;
      rd_data_d  = (is_load & ~misaligned) ? load_data : rdWriteDataM;
      pc_d       = pcM;
      inst_d     = instM;
      misalign_d = misaligned;
      commit_d   = ~((instM == 32'd0) & ~access & ~rdWriteEnableM);
      rd_we_d    = rdWriteEnableM & ~RamWriteEnableM & ~misaligned;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_we_q    <= 1'b0;
      rd_addr_q  <= 5'd0;
      rd_data_q  <= 64'd0;
      pc_q       <= 64'd0;
      inst_q     <= 32'd0;
      commit_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_we_q    <= rd_we_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      commit_q   <= commit_d;
      misalign_q <= misalign_d;
    end
  end

  assign rdWriteEnableW = rd_we_q;
  assign rdWriteAddrW   = rd_addr_q;
  assign rdWriteDataW   = rd_data_q;
  assign pcW            = pc_q;
  assign instW          = inst_q;
  assign commitW        = commit_q;
  assign misalignW      = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random memory/ALU traffic checked
// against a byte-level reference model of load/store behaviour.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pcM, RamReadAddrM, RamWriteAddrM, RamWriteDataM, rdWriteDataM;
  logic [31:0] instM;
  logic [10:0] memFuncM;
  logic        RamReadEnableM, RamWriteEnableM, rdWriteEnableM;
  logic [4:0]  rdWriteAddrM;
  logic        ram_req, ram_we, ram_ready;
  logic [63:0] ram_addr, ram_wdata, ram_rdata;
  logic [7:0]  ram_wmask;
  logic        stallReqM, rdWriteEnableW, commitW, misalignW;
  logic [4:0]  rdWriteAddrW;
  logic [63:0] rdWriteDataW, pcW;
  logic [31:0] instW;

  int n_checks = 0;
  int n_fail   = 0;
  int last_stalls;
  logic [63:0] obs_addr, obs_wdata;
  logic [7:0]  obs_wmask;
  logic        obs_req, obs_we;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .pcM(pcM), .instM(instM), .memFuncM(memFuncM),
    .RamReadAddrM(RamReadAddrM), .RamWriteAddrM(RamWriteAddrM), .RamWriteDataM(RamWriteDataM),
    .RamReadEnableM(RamReadEnableM), .RamWriteEnableM(RamWriteEnableM),
    .rdWriteEnableM(rdWriteEnableM), .rdWriteAddrM(rdWriteAddrM), .rdWriteDataM(rdWriteDataM),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wmask(ram_wmask), .ram_ready(ram_ready), .ram_rdata(ram_rdata),
    .stallReqM(stallReqM), .rdWriteEnableW(rdWriteEnableW), .rdWriteAddrW(rdWriteAddrW),
    .rdWriteDataW(rdWriteDataW), .pcW(pcW), .instW(instW), .commitW(commitW),
    .misalignW(misalignW)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    pcM = '0; instM = '0; memFuncM = '0; RamReadAddrM = '0; RamWriteAddrM = '0;
    RamWriteDataM = '0; RamReadEnableM = 0; RamWriteEnableM = 0; rdWriteEnableM = 0;
    rdWriteAddrM = '0; rdWriteDataM = '0; ram_ready = 0; ram_rdata = '0;
  endtask

  function automatic int width_of(input int op);
    case (op)
      0, 4, 7: return 1;
      1, 5, 8: return 2;
      2, 6, 9: return 4;
      default: return 8;
    endcase
  endfunction

  // op: 0..10 = lb,lh,lw,ld,lbu,lhu,lwu,sb,sh,sw,sd; -1 = ALU op; -2 = bubble.
  // stalls = cycles the RAM withholds ram_ready after the request appears.
  task automatic run_txn(input int op, input logic [63:0] addr, input logic [63:0] sdata,
                         input logic [63:0] rdata, input int stalls, input logic rdwe,
                         input logic [4:0] rda, input logic [63:0] rdd,
                         input logic [63:0] pc, input logic [31:0] inst);
    bit is_mem   = (op >= 0);
    bit is_store = (op >= 7);
    bit is_load  = is_mem && !is_store;
    int w        = width_of(op);
    int o        = int'(addr % 8);
    bit mis      = is_mem && ((addr % 64'(w)) != 0);
    bit req_exp  = is_mem && !mis;
    logic [63:0] mask, val, exp_wdata;
    logic [7:0]  exp_wmask;
    mask = (w == 8) ? '1 : ((64'd1 << (8 * w)) - 64'd1);
    exp_wmask = 8'(((1 << w) - 1) << o);
    exp_wdata = (sdata & mask) << (8 * o);
    val = (rdata >> (8 * o)) & mask;
    if (op <= 2 && op >= 0 && val[8 * w - 1]) val = val | ~mask;

    @(posedge clk); #1;
    memFuncM        = is_mem ? (11'd1 << op) : 11'd0;
    RamReadEnableM  = is_load;
    RamWriteEnableM = is_store;
    RamReadAddrM    = is_load ? addr : {$urandom, $urandom};
    RamWriteAddrM   = is_store ? addr : {$urandom, $urandom};
    RamWriteDataM   = sdata;
    rdWriteEnableM  = rdwe;
    rdWriteAddrM    = rda;
    rdWriteDataM    = rdd;
    pcM             = pc;
    instM           = inst;
    ram_ready       = (stalls == 0) ? (req_exp ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
    ram_rdata       = (stalls == 0) ? rdata : {$urandom, $urandom};
    #1;
    obs_req = ram_req; obs_addr = ram_addr; obs_we = ram_we;
    obs_wmask = ram_wmask; obs_wdata = ram_wdata;
    chk("ram_req", ram_req, req_exp);
    if (req_exp) begin
      chk("ram_addr", ram_addr, addr & ~64'd7);
      chk("ram_we", ram_we, is_store);
      if (is_store) begin
        chk("ram_wmask", ram_wmask, exp_wmask);
        chk("ram_wdata", ram_wdata, exp_wdata);
      end
    end
    last_stalls = 0;
    if (req_exp) begin
      for (int c = 0; c < stalls; c++) begin
        chk("stall_wait", stallReqM, 1);
        chk("req_wait", ram_req, 1);
        chk("addr_wait", ram_addr, addr & ~64'd7);
        last_stalls++;
        @(posedge clk); #1;
        chk("commit_bubble", commitW, 0);
        chk("rdwe_bubble", rdWriteEnableW, 0);
        if (c == stalls - 1) begin
          ram_ready = 1;
          ram_rdata = rdata;
        end
        #1;
      end
    end
    chk("stall_done", stallReqM, 0);
    @(posedge clk); #1;
    chk("commitW", commitW, (op != -2));
    chk("rdWriteEnableW", rdWriteEnableW, (is_store || mis) ? 1'b0 : rdwe);
    chk("misalignW", misalignW, mis);
    chk("pcW", pcW, pc);
    chk("instW", instW, 64'(inst));
    chk("rdWriteAddrW", rdWriteAddrW, 64'(rda));
    if (!is_mem) chk("rdData_alu", rdWriteDataW, rdd);
    if (is_load && !mis) chk("rdData_load", rdWriteDataW, val);
    $display("txn op=%0d addr=%h stalls=%0d mis=%0d rdW=%h", op, addr, last_stalls, mis, rdWriteDataW);
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    // Present an aligned ld during reset: no request and no stall may leak out.
    memFuncM = 11'd1 << 3; RamReadEnableM = 1; RamReadAddrM = 64'h8000_0008;
    @(posedge clk); #1;
    chk("rst_req", ram_req, 0);
    chk("rst_stall", stallReqM, 0);
    @(posedge clk); #1;
    chk("rst_commit", commitW, 0);
    chk("rst_rdwe", rdWriteEnableW, 0);
    chk("rst_misalign", misalignW, 0);
    chk("rst_rdaddr", rdWriteAddrW, 0);
    chk("rst_rddata", rdWriteDataW, 0);
    chk("rst_pc", pcW, 0);
    chk("rst_inst", instW, 0);
    clear_inputs();
    rst = 0;

    // add x5
    run_txn(-1, 0, 0, 0, 0, 1, 5, 64'h1234, 64'h100, 32'h0053_02B3);
    chk("add_rdW", rdWriteDataW, 64'h1234);
    chk("add_stalls", 64'(last_stalls), 0);

    // lb with a slow RAM
    run_txn(0, 64'h8000_0003, 0, 64'h0000_0000_80FF_0000, 3, 1, 7, 0, 64'h104, 32'h0031_8383);
    chk("lb_addr", obs_addr, 64'h8000_0000);
    chk("lb_stalls", 64'(last_stalls), 3);
    chk("lb_data", rdWriteDataW, 64'hFFFF_FFFF_FFFF_FF80);

    // sh zero-wait
    run_txn(8, 64'h8000_0006, 64'hABCD, 0, 0, 0, 0, 0, 64'h108, 32'h00A3_1323);
    chk("sh_wmask", 64'(obs_wmask), 64'hC0);
    chk("sh_wdata", obs_wdata, 64'hABCD_0000_0000_0000);
    chk("sh_we", obs_we, 1);
    chk("sh_commit", commitW, 1);

    // misaligned lw
    run_txn(2, 64'h8000_0002, 0, 0, 0, 1, 9, 0, 64'h10C, 32'h0021_2483);
    chk("lw_mis_req", obs_req, 0);
    chk("lw_mis_flag", misalignW, 1);

    // lwu zero-wait
    run_txn(6, 64'h8000_0004, 0, 64'h8765_4321_0000_0000, 0, 1, 10, 0, 64'h110, 32'h0042_6503);
    chk("lwu_data", rdWriteDataW, 64'h0000_0000_8765_4321);

    // ld abandoned by reset while waiting
    @(posedge clk); #1;
    memFuncM = 11'd1 << 3; RamReadEnableM = 1; RamReadAddrM = 64'h8000_0010;
    rdWriteEnableM = 1; rdWriteAddrM = 5'd11; pcM = 64'h114; instM = 32'h0101_3583;
    #1;
    chk("ld_rst_stall0", stallReqM, 1);
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("ld_rst_req", ram_req, 0);
    chk("ld_rst_stall", stallReqM, 0);
    @(posedge clk); #1;
    rst = 0;
    clear_inputs();
    ram_ready = 1; ram_rdata = 64'hDEAD_BEEF_0BAD_F00D;
    #1;
    chk("ld_post_req", ram_req, 0);
    chk("ld_post_stall", stallReqM, 0);
    chk("ld_post_commit", commitW, 0);
    chk("ld_post_rdwe", rdWriteEnableW, 0);
    chk("ld_post_pc", pcW, 0);
    @(posedge clk); #1;
    chk("ld_post2_commit", commitW, 0);
    chk("ld_post2_data", rdWriteDataW, 0);
    chk("ld_post2_inst", instW, 0);
    clear_inputs();

    for (int t = 0; t < 60; t++) begin
      int op = int'($urandom_range(0, 12)) - 2;
      logic [63:0] a = 64'h8000_0000 + 64'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1 && op >= 0) a = a & ~(64'(width_of(op)) - 64'd1);
      if (op == -2)
        run_txn(op, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0);
      else
        run_txn(op, a, {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)), {$urandom, $urandom},
                {$urandom, $urandom}, $urandom | 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
